rotate_arbiter: RTL and testbench
=================================

// Module: rotate_arbiter
// PURPOSE
//  Shares one 8-bit right-rotate datapath (existing module right_shift) between NUM_REQ requesters.
//  Round-robin arbiter with a valid/ready request per requester and one registered response channel.
//  Response carries the rotated byte and the winning requester ID.
//  Sits between the requesting units and the rotate datapath; no other access to the rotator.
// PARAMETERS
//  NUM_REQ  4                        number of requesters, 2..8
//  IDW      $clog2(NUM_REQ) (local)  width of requester ID
// PORTS
//  clk        in   1          single clock, all logic on rising edge
//  rst        in   1          synchronous, active-high reset
//  req_valid  in   NUM_REQ    per-requester request valid
//  req_ready  out  NUM_REQ    per-requester accept; at most one bit set (one-hot or zero)
//  req_data   in   NUM_REQ*8  per-requester operand; slice i = [8*i+7:8*i]
//  req_shift  in   NUM_REQ*3  per-requester rotate amount 0..7; slice i = [3*i+2:3*i]
//  rsp_valid  out  1          response valid
//  rsp_ready  in   1          response consumer ready
//  rsp_data   out  8          rotated result
//  rsp_id     out  IDW        index of the requester that owns rsp_data
//  busy       out  1          equals rsp_valid; held response pending
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): rsp_valid=0, rsp_data=0, rsp_id=0, rr_ptr=0.
//    While rst=1, req_ready=0 combinationally.
//  - Slot is free when rsp_valid=0 or (rsp_valid & rsp_ready); the latter gives back-to-back throughput.
//  - Winner: first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//  - req_ready[winner]=1 only when the slot is free. Combinational from req_valid, rr_ptr, rsp_valid, rsp_ready.
//  - Request handshake i = req_valid[i] & req_ready[i]. At that edge:
//    - rsp_data <= rotr(req_data[i], req_shift[i])
//    - rsp_id <= i
//    - rsp_valid <= 1
//    - rr_ptr <= (i+1) mod NUM_REQ
//  - Latency: exactly 1 cycle from request handshake to rsp_valid.
//  - Slot free and no req_valid: rsp_valid <= 0. rr_ptr and rsp_data/rsp_id are unchanged (stale data allowed).
//  - rsp_valid & !rsp_ready: rsp_data, rsp_id and rsp_valid are held stable. All req_ready=0. No request is dropped.
//  - Rotation: rotr(x,s) = {x[s-1:0], x[7:s]}; s=0 passes x unchanged. No widening.
//  - Fairness: a continuously asserted req_valid is granted within NUM_REQ handshakes.
//  - rr_ptr wraps from NUM_REQ-1 to 0. Non-power-of-2 NUM_REQ never selects an index >= NUM_REQ.
//  - Reset mid-operation: a pending response is discarded (rsp_valid=0 next cycle). No grant is issued in the reset cycle.
//  - Requesters may deassert req_valid without a handshake; the arbiter holds no lock.
// CONFIGURATION
//  ROTATE_LEFT_EN defined:
//    - adds input port req_dir [NUM_REQ-1:0]; 1 = rotate left
//    - left rotate by s uses right-rotate amount (8-s) mod 8 on the same datapath
//    - rsp_data = rotl(x,s)
//  ROTATE_LEFT_EN undefined:
//    - port req_dir absent; all requests rotate right
//  Timing and arbitration are identical in both builds.
// STRUCTURE
//  Package rotate_pkg:
//    - ROT_W=8 and SHIFT_W=3 constants
//    - function rr_next(ptr, n) for pointer wrap
//  Sub-module rr_pick:
//    - combinational round-robin priority picker
//    - inputs: req vector, rr_ptr
//    - outputs: one-hot grant, grant index, any_req
//  Top level:
//    - instantiates rr_pick and one right_shift
//    - operand/amount mux driven by the grant index
//    - response register; rr_ptr register
// TESTING
//  1. Reset, then req_valid[2]=1, data=8'hB1, shift=3:
//     req_ready[2]=1 same cycle; next cycle rsp_valid=1, rsp_data=8'h36, rsp_id=2.
//  2. All 4 req_valid held, rsp_ready=1:
//     grant order 0,1,2,3,0,...; one response per cycle; rsp_id sequence matches.
//  3. rsp_ready=0 for 5 cycles with requests pending:
//     rsp_data/rsp_id stable; all req_ready=0; rsp_ready=1 releases the next grant in the same cycle.
//  4. Shift 0 and 7 on data 8'h81:
//     results 8'h81 and 8'h03; rr_ptr wrap 3->0 checked.
//  5. rst=1 while rsp_valid=1:
//     next cycle rsp_valid=0, rsp_data=0, rsp_id=0; first grant after reset goes to requester 0.
//  6. ROTATE_LEFT_EN build, req_dir=1, data=8'h81, shift=1:
//     rsp_data=8'h03; same stimulus with req_dir=0 gives 8'hC0.

Source files
------------

// File: rtl/rotate_pkg.sv
// Shared constants and helpers for the rotate arbiter slice.
// Optional feature macro used by this slice: ROTATE_LEFT_EN (adds left rotation).
package rotate_pkg;

   localparam int ROT_W   = 8;
   localparam int SHIFT_W = 3;

   // Advance a round-robin pointer by one, wrapping at n.
   function automatic int rr_next(input int ptr, input int n);
      return (ptr + 1 >= n) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/right_shift.sv
// 8-bit right-rotate datapath: dout = {din[amt-1:0], din[7:amt]}, amt=0 passes din.
module right_shift
   import rotate_pkg::*;
(
   input  logic [ROT_W-1:0]   din,
   input  logic [SHIFT_W-1:0] amt,
   output logic [ROT_W-1:0]   dout
);

   logic [2*ROT_W-1:0] dbl;

   // Shifting the doubled operand right drops the wrapped-around bits into the low byte.
   always_comb begin
      dbl  = {din, din} >> amt;
      dout = dbl[ROT_W-1:0];
   end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at N.
module rr_pick #(
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [N-1:0]   grant,
   output logic [IDW-1:0] grant_idx,
   output logic           any_req
);

   logic [IDW-1:0] cand_idx [N];
   logic [N-1:0]   cand_req;

   // Candidate k is the requester k positions after the pointer; modulo keeps it below N.
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_cand
         assign cand_idx[gi] = IDW'((int'(ptr) + gi) % N);
         assign cand_req[gi] = req[cand_idx[gi]];
      end
   endgenerate

   // Scan from the farthest candidate down so the nearest active one wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_req   = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (cand_req[k]) begin
            any_req   = 1'b1;
            grant_idx = cand_idx[k];
         end
      end
      if (any_req) begin
         grant[grant_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/rotate_arbiter.sv
// Round-robin arbiter sharing one right_shift rotator between NUM_REQ requesters,
// with a single registered response channel.
// Optional feature macro: ROTATE_LEFT_EN adds per-requester req_dir (1 = rotate left).
module rotate_arbiter
   import rotate_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*ROT_W-1:0]   req_data,
   input  logic [NUM_REQ*SHIFT_W-1:0] req_shift,
`ifdef ROTATE_LEFT_EN
   input  logic [NUM_REQ-1:0]         req_dir,
`endif
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [ROT_W-1:0]           rsp_data,
   output logic [IDW-1:0]             rsp_id,
   output logic                       busy
);

   logic [ROT_W-1:0]   data_arr  [NUM_REQ];
   logic [SHIFT_W-1:0] shift_arr [NUM_REQ];

   logic [NUM_REQ-1:0] grant;
   logic [IDW-1:0]     grant_idx;
   logic               any_req;

   logic [IDW-1:0]     rr_ptr_reg;
   logic               rsp_valid_reg;
   logic [ROT_W-1:0]   rsp_data_reg;
   logic [IDW-1:0]     rsp_id_reg;

   logic [ROT_W-1:0]   sel_data;
   logic [SHIFT_W-1:0] sel_amt;
   logic [ROT_W-1:0]   rot_out;
   logic               slot_free;
   logic               accept;

   // Unpack the flat operand buses into per-requester slices.
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign data_arr[gi]  = req_data[gi*ROT_W +: ROT_W];
         assign shift_arr[gi] = req_shift[gi*SHIFT_W +: SHIFT_W];
      end
   endgenerate

   rr_pick #(
      .N   (NUM_REQ),
      .IDW (IDW)
   ) u_pick (
      .req       (req_valid),
      .ptr       (rr_ptr_reg),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_req   (any_req)
   );

   // Slot frees up when empty or when the held response is being taken this cycle.
   always_comb begin
      slot_free = !rsp_valid_reg || rsp_ready;
      accept    = any_req && slot_free && !rst;
      req_ready = accept ? grant : '0;
   end

   // Steer the winner's operand to the rotator; a left rotate by s is a right rotate by -s mod 8.
   always_comb begin
      sel_data = data_arr[grant_idx];
`ifdef ROTATE_LEFT_EN
      sel_amt  = req_dir[grant_idx] ? (SHIFT_W'(0) - shift_arr[grant_idx]) : shift_arr[grant_idx];
`else
      sel_amt  = shift_arr[grant_idx];
`endif
   end

   right_shift u_rot (
      .din  (sel_data),
      .amt  (sel_amt),
      .dout (rot_out)
   );

   // Response register and round-robin pointer; a stalled response holds everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid_reg <= 1'b0;
         rsp_data_reg  <= '0;
         rsp_id_reg    <= '0;
         rr_ptr_reg    <= '0;
      end else if (accept) begin
         rsp_valid_reg <= 1'b1;
         rsp_data_reg  <= rot_out;
         rsp_id_reg    <= grant_idx;
         rr_ptr_reg    <= IDW'(rr_next(int'(grant_idx), NUM_REQ));
      end else if (slot_free) begin
         rsp_valid_reg <= 1'b0;
      end
   end

   assign rsp_valid = rsp_valid_reg;
   assign rsp_data  = rsp_data_reg;
   assign rsp_id    = rsp_id_reg;
   assign busy      = rsp_valid_reg;

endmodule

// File: tb/tb_rotate_arbiter.sv
// Scoreboard bench for rotate_arbiter: directed scenarios plus randomized traffic,
// checked against a behavioural model of the arbitration and rotation rules.
module tb_rotate_arbiter;

   localparam int N = 4;

   typedef struct {
      int data;
      int id;
   } rsp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     req_valid;
   logic [N-1:0]     req_ready;
   logic [N*8-1:0]   req_data;
   logic [N*3-1:0]   req_shift;
   logic [N-1:0]     req_dir;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [7:0]       rsp_data;
   logic [1:0]       rsp_id;
   logic             busy;

   int   n_checks = 0;
   int   n_errors = 0;
   rsp_t exp_q[$];
   int   m_ptr    = 0;
   bit   m_valid  = 1'b0;
   bit   prev_rst = 1'b0;

   always #5 clk = ~clk;

   rotate_arbiter #(.NUM_REQ(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
      .req_shift (req_shift),
`ifdef ROTATE_LEFT_EN
      .req_dir   (req_dir),
`endif
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .busy      (busy)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int rot_ref(input int x, input int s, input bit left);
      int r;
      if (left) r = ((x << s) | (x >> (8 - s))) & 255;
      else      r = ((x >> s) | (x << (8 - s))) & 255;
      return r;
   endfunction

   // Behavioural model, evaluated once per cycle at the falling edge.
   task automatic model_step();
      int  w;
      bit  free;
      int  exp_ready;
      int  x, s;
      bit  left;
      rsp_t e;
      if (prev_rst) begin
         chk("rst_data", int'(rsp_data), 0);
         chk("rst_id", int'(rsp_id), 0);
      end
      chk("rsp_valid", int'(rsp_valid), int'(m_valid));
      chk("busy", int'(busy), int'(m_valid));
      w = -1;
      for (int k = 0; k < N; k++) begin
         if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      end
      free = !m_valid || rsp_ready;
      exp_ready = (!rst && free && w >= 0) ? (1 << w) : 0;
      chk("req_ready", int'(req_ready), exp_ready);
      if (rst) begin
         m_valid = 1'b0;
         m_ptr   = 0;
         exp_q.delete();
      end else if (exp_ready != 0) begin
         x = int'(req_data[w*8 +: 8]);
         s = int'(req_shift[w*3 +: 3]);
`ifdef ROTATE_LEFT_EN
         left = req_dir[w];
`else
         left = 1'b0;
`endif
         e.data = rot_ref(x, s, left);
         e.id   = w;
         exp_q.push_back(e);
         m_valid = 1'b1;
         m_ptr   = (w + 1) % N;
      end else if (free) begin
         m_valid = 1'b0;
      end
      prev_rst = rst;
   endtask

   task automatic tick();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every presented response must match the oldest outstanding expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (rst === 1'b0 && rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_rsp", 1, 0);
            end else begin
               $display("rsp id=%0d data=%02h ready=%0b", rsp_id, rsp_data, rsp_ready);
               chk("rsp_data", int'(rsp_data), exp_q[0].data);
               chk("rsp_id", int'(rsp_id), exp_q[0].id);
               if (rsp_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; req_valid = '0; req_data = '0; req_shift = '0; req_dir = '0; rsp_ready = 1'b1;
      @(posedge clk); #1;
      tick(); tick();
      rst = 1'b0;

      // Single request from requester 2: B1 rotated right by 3.
      req_valid = 4'b0100; req_data[23:16] = 8'hB1; req_shift[8:6] = 3'd3;
      tick();
      chk("t1_data", int'(rsp_data), 8'h36);
      chk("t1_id", int'(rsp_id), 2);
      req_valid = '0;
      tick();

      // All requesters active, consumer always ready.
      req_valid = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         req_data  = {$urandom, $urandom};
         req_shift = 12'($urandom);
         tick();
      end

      // Consumer stalls for five cycles with requests pending, then releases.
      rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      rsp_ready = 1'b1;
      tick();
      req_valid = '0;
      tick();

      // Shift 7 on requester 3, then shift 0 on requester 0 after the pointer wraps.
      req_data = {4{8'h81}};
      req_valid = 4'b1000; req_shift = {3'd7, 3'd0, 3'd0, 3'd0};
      tick();
      chk("t4_rot7", int'(rsp_data), 8'h03);
      req_valid = 4'b0001;
      tick();
      chk("t4_rot0", int'(rsp_data), 8'h81);
      chk("t4_wrap_id", int'(rsp_id), 0);
      req_valid = '0;
      tick();

      // Reset while a stalled response is pending.
      req_valid = 4'b0010; rsp_ready = 1'b0;
      tick();
      req_valid = '0;
      tick();
      rst = 1'b1; req_valid = 4'b1111;
      tick();
      rst = 1'b0; rsp_ready = 1'b1;
      tick();
      chk("t5_first_id", int'(rsp_id), 0);
      req_valid = '0;
      tick();

`ifdef ROTATE_LEFT_EN
      // Direction select on the same operand.
      req_data = {4{8'h81}}; req_shift = {4{3'd1}};
      req_valid = 4'b0010; req_dir = 4'b0010;
      tick();
      chk("t6_left", int'(rsp_data), 8'h03);
      req_valid = 4'b0100; req_dir = 4'b0000;
      tick();
      chk("t6_right", int'(rsp_data), 8'hC0);
      req_valid = '0;
      tick();
`endif

      // Randomized traffic with occasional stalls and resets.
      for (int i = 0; i < 400; i++) begin
         req_valid = N'($urandom);
         req_data  = {$urandom, $urandom};
         req_shift = 12'($urandom);
         req_dir   = N'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
         rst       = ($urandom_range(0, 63) == 0);
         tick();
      end

      // Drain outstanding responses.
      rst = 1'b0; req_valid = '0; rsp_ready = 1'b1;
      tick(); tick();
      chk("drain_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
